// File: rtl/alu_issue_stage_if.sv
// Bundle of decode-side, forwarding and ALU-side signals for the ALU issue stage.
// The master modport belongs to whoever drives decode/forwarding and consumes the ALU inputs.
interface alu_issue_stage_if #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
);
    logic                i_valid;
    logic                o_ready;
    logic [ALU_OP_W-1:0] i_alu_op;
    logic [4:0]          i_rs1_addr;
    logic [4:0]          i_rs2_addr;
    logic [XLEN-1:0]     i_rs1_data;
    logic [XLEN-1:0]     i_rs2_data;
    logic [XLEN-1:0]     i_imm;
    logic [XLEN-1:0]     i_pc;
    logic                i_sel_a;
    logic                i_sel_b;
    logic [4:0]          i_rd_addr;
    logic                i_rd_we;

    logic                i_ex_we;
    logic [4:0]          i_ex_rd;
    logic [XLEN-1:0]     i_ex_data;
    logic                i_ex_is_load;
    logic                i_wb_we;
    logic [4:0]          i_wb_rd;
    logic [XLEN-1:0]     i_wb_data;

    logic                i_flush;
    logic                o_valid;
    logic                i_ready;
    logic [ALU_OP_W-1:0] o_alu_op;
    logic [XLEN-1:0]     o_data_1;
    logic [XLEN-1:0]     o_data_2;
    logic [XLEN-1:0]     o_rs2_val;
    logic [4:0]          o_rd_addr;
    logic                o_rd_we;
    logic [XLEN-1:0]     o_pc;
    logic                o_stall;

    modport master (
        output i_valid, i_alu_op, i_rs1_addr, i_rs2_addr, i_rs1_data, i_rs2_data,
               i_imm, i_pc, i_sel_a, i_sel_b, i_rd_addr, i_rd_we,
               i_ex_we, i_ex_rd, i_ex_data, i_ex_is_load, i_wb_we, i_wb_rd, i_wb_data,
               i_flush, i_ready,
        input  o_ready, o_valid, o_alu_op, o_data_1, o_data_2, o_rs2_val,
               o_rd_addr, o_rd_we, o_pc, o_stall
    );

    modport slave (
        input  i_valid, i_alu_op, i_rs1_addr, i_rs2_addr, i_rs1_data, i_rs2_data,
               i_imm, i_pc, i_sel_a, i_sel_b, i_rd_addr, i_rd_we,
               i_ex_we, i_ex_rd, i_ex_data, i_ex_is_load, i_wb_we, i_wb_rd, i_wb_data,
               i_flush, i_ready,
        output o_ready, o_valid, o_alu_op, o_data_1, o_data_2, o_rs2_val,
               o_rd_addr, o_rd_we, o_pc, o_stall
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: forwards rs1/rs2 from EX/WB, selects ALU operands and holds them
// in a one-entry valid/ready slot; stalls decode on a load-use hazard.
module alu_issue_stage #(
    parameter int                       XLEN        = 32,
    parameter int                       ALU_OP_W    = 4,
    parameter logic [(1<<ALU_OP_W)-1:0] RS2_VAL_OPS = '0
) (
    input logic             i_clk,
    input logic             i_rst_n,
    alu_issue_stage_if.slave bus
);
    logic                valid_q,   valid_d;
    logic [ALU_OP_W-1:0] aluOp_q,   aluOp_d;
    logic [XLEN-1:0]     data1_q,   data1_d;
    logic [XLEN-1:0]     data2_q,   data2_d;
    logic [XLEN-1:0]     rs2Val_q,  rs2Val_d;
    logic [4:0]          rdAddr_q,  rdAddr_d;
    logic                rdWe_q,    rdWe_d;
    logic [XLEN-1:0]     pc_q,      pc_d;

    logic [XLEN-1:0] rs1Fwd;
    logic [XLEN-1:0] rs2Fwd;
    logic            rs1Used;
    logic            rs2Used;
    logic            stall;
    logic            ready;
    logic            accept;

    // EX result beats WB result beats the regfile; x0 is hardwired to zero
    always_comb begin
        rs1Fwd = bus.i_rs1_data;
        if (bus.i_rs1_addr == 5'd0)
            rs1Fwd = '0;
        else if (bus.i_ex_we && bus.i_ex_rd == bus.i_rs1_addr)
            rs1Fwd = bus.i_ex_data;
        else if (bus.i_wb_we && bus.i_wb_rd == bus.i_rs1_addr)
            rs1Fwd = bus.i_wb_data;

        rs2Fwd = bus.i_rs2_data;
        if (bus.i_rs2_addr == 5'd0)
            rs2Fwd = '0;
        else if (bus.i_ex_we && bus.i_ex_rd == bus.i_rs2_addr)
            rs2Fwd = bus.i_ex_data;
        else if (bus.i_wb_we && bus.i_wb_rd == bus.i_rs2_addr)
            rs2Fwd = bus.i_wb_data;
    end

    // A load in EX has no data yet, so any consumer of its rd must wait one cycle
    always_comb begin
        rs1Used = !bus.i_sel_a;
        rs2Used = !bus.i_sel_b || RS2_VAL_OPS[bus.i_alu_op];
        stall   = bus.i_valid && bus.i_ex_we && bus.i_ex_is_load && (bus.i_ex_rd != 5'd0) &&
                  ((rs1Used && bus.i_ex_rd == bus.i_rs1_addr) ||
                   (rs2Used && bus.i_ex_rd == bus.i_rs2_addr));
        ready   = !stall && (!valid_q || bus.i_ready);
        accept  = bus.i_valid && ready;
    end

    always_comb begin
        valid_d  = valid_q;
        aluOp_d  = aluOp_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        rs2Val_d = rs2Val_q;
        rdAddr_d = rdAddr_q;
        rdWe_d   = rdWe_q;
        pc_d     = pc_q;

        if (bus.i_flush)
            valid_d = 1'b0;
        else if (accept)
            valid_d = 1'b1;
        else if (bus.i_ready)
            valid_d = 1'b0;

        if (accept && !bus.i_flush) begin
            aluOp_d  = bus.i_alu_op;
            data1_d  = bus.i_sel_a ? bus.i_pc  : rs1Fwd;
            data2_d  = bus.i_sel_b ? bus.i_imm : rs2Fwd;
            rs2Val_d = rs2Fwd;
            rdAddr_d = bus.i_rd_addr;
            rdWe_d   = bus.i_rd_we;
            pc_d     = bus.i_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q  <= 1'b0;
            aluOp_q  <= '0;
            data1_q  <= '0;
            data2_q  <= '0;
            rs2Val_q <= '0;
            rdAddr_q <= '0;
            rdWe_q   <= 1'b0;
            pc_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            aluOp_q  <= aluOp_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            rs2Val_q <= rs2Val_d;
            rdAddr_q <= rdAddr_d;
            rdWe_q   <= rdWe_d;
            pc_q     <= pc_d;
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_stall   = stall;
    assign bus.o_valid   = valid_q;
    assign bus.o_alu_op  = aluOp_q;
    assign bus.o_data_1  = data1_q;
    assign bus.o_data_2  = data2_q;
    assign bus.o_rs2_val = rs2Val_q;
    assign bus.o_rd_addr = rdAddr_q;
    assign bus.o_rd_we   = rdWe_q;
    assign bus.o_pc      = pc_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: reset, forwarding, load-use stall, immediate select,
// backpressure hold, flush and asynchronous reset while holding.
module tb_alu_issue_stage;
    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 4;

    logic i_clk;
    logic i_rst_n;
    int   checks;
    int   failures;

    alu_issue_stage_if #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W)) bus ();

    alu_issue_stage #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.i_valid      = 1'b0;
        bus.i_alu_op     = '0;
        bus.i_rs1_addr   = '0;
        bus.i_rs2_addr   = '0;
        bus.i_rs1_data   = '0;
        bus.i_rs2_data   = '0;
        bus.i_imm        = '0;
        bus.i_pc         = '0;
        bus.i_sel_a      = 1'b0;
        bus.i_sel_b      = 1'b0;
        bus.i_rd_addr    = '0;
        bus.i_rd_we      = 1'b0;
        bus.i_ex_we      = 1'b0;
        bus.i_ex_rd      = '0;
        bus.i_ex_data    = '0;
        bus.i_ex_is_load = 1'b0;
        bus.i_wb_we      = 1'b0;
        bus.i_wb_rd      = '0;
        bus.i_wb_data    = '0;
        bus.i_flush      = 1'b0;
        bus.i_ready      = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.o_valid); end
        checks++;
        if (bus.o_data_1 !== 32'h0) begin failures++; $display("[TB] FAIL reset_data1 got=%h exp=0", bus.o_data_1); end
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_stall !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_ready_stall got=%b%b exp=10", bus.o_ready, bus.o_stall);
        end
        step();
        step();
        i_rst_n = 1'b1;
    endtask

    task automatic test_basic();
        clearInputs();
        bus.i_valid = 1'b1; bus.i_alu_op = 4'h0;
        bus.i_rs1_addr = 5'd1; bus.i_rs1_data = 32'd5;
        bus.i_rs2_addr = 5'd2; bus.i_rs2_data = 32'd7;
        bus.i_rd_addr = 5'd3; bus.i_rd_we = 1'b1; bus.i_pc = 32'h40;
        step();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data_1 !== 32'd5 || bus.o_data_2 !== 32'd7) begin
            failures++; $display("[TB] FAIL basic_operands got=%b/%h/%h exp=1/5/7", bus.o_valid, bus.o_data_1, bus.o_data_2);
        end
        checks++;
        if (bus.o_rd_addr !== 5'd3 || bus.o_rd_we !== 1'b1 || bus.o_pc !== 32'h40 || bus.o_rs2_val !== 32'd7) begin
            failures++; $display("[TB] FAIL basic_passthru got=%h/%b/%h/%h exp=3/1/40/7",
                                 bus.o_rd_addr, bus.o_rd_we, bus.o_pc, bus.o_rs2_val);
        end
        bus.i_valid = 1'b0;
        step();
        checks++;
        if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_drain got=%b exp=0", bus.o_valid); end
    endtask

    task automatic test_forward();
        clearInputs();
        bus.i_valid = 1'b1;
        bus.i_rs1_addr = 5'd1; bus.i_rs1_data = 32'd5;
        bus.i_rs2_addr = 5'd2; bus.i_rs2_data = 32'd7;
        bus.i_ex_we = 1'b1; bus.i_ex_rd = 5'd1; bus.i_ex_data = 32'h100;
        bus.i_wb_we = 1'b1; bus.i_wb_rd = 5'd1; bus.i_wb_data = 32'h200;
        step();
        checks++;
        if (bus.o_data_1 !== 32'h100) begin failures++; $display("[TB] FAIL fwd_ex_wins got=%h exp=100", bus.o_data_1); end
        bus.i_ex_we = 1'b0; bus.i_rs2_addr = 5'd1;
        step();
        checks++;
        if (bus.o_data_1 !== 32'h200 || bus.o_data_2 !== 32'h200) begin
            failures++; $display("[TB] FAIL fwd_wb got=%h/%h exp=200/200", bus.o_data_1, bus.o_data_2);
        end
        bus.i_rs1_addr = 5'd0; bus.i_rs1_data = 32'h55;
        bus.i_ex_we = 1'b1; bus.i_ex_rd = 5'd0; bus.i_ex_data = 32'h300;
        bus.i_wb_rd = 5'd0;
        step();
        checks++;
        if (bus.o_data_1 !== 32'h0 || bus.o_valid !== 1'b1) begin
            failures++; $display("[TB] FAIL fwd_x0 got=%h/%b exp=0/1", bus.o_data_1, bus.o_valid);
        end
        clearInputs();
        step();
    endtask

    task automatic test_load_use();
        clearInputs();
        bus.i_valid = 1'b1;
        bus.i_rs1_addr = 5'd1; bus.i_rs1_data = 32'd5;
        bus.i_rs2_addr = 5'd3; bus.i_rs2_data = 32'h11;
        bus.i_ex_we = 1'b1; bus.i_ex_is_load = 1'b1; bus.i_ex_rd = 5'd3; bus.i_ex_data = 32'hDEAD;
        #1;
        checks++;
        if (bus.o_stall !== 1'b1 || bus.o_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL loaduse_stall got=%b%b exp=10", bus.o_stall, bus.o_ready);
        end
        step();
        checks++;
        if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL loaduse_bubble got=%b exp=0", bus.o_valid); end
        bus.i_ex_we = 1'b0; bus.i_ex_is_load = 1'b0; bus.i_ex_rd = 5'd0;
        bus.i_wb_we = 1'b1; bus.i_wb_rd = 5'd3; bus.i_wb_data = 32'hABC;
        #1;
        checks++;
        if (bus.o_stall !== 1'b0 || bus.o_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL loaduse_release got=%b%b exp=01", bus.o_stall, bus.o_ready);
        end
        step();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data_2 !== 32'hABC || bus.o_rs2_val !== 32'hABC || bus.o_data_1 !== 32'd5) begin
            failures++; $display("[TB] FAIL loaduse_wbfwd got=%b/%h/%h/%h exp=1/abc/abc/5",
                                 bus.o_valid, bus.o_data_2, bus.o_rs2_val, bus.o_data_1);
        end
        clearInputs();
        step();
    endtask

    task automatic test_sel_imm();
        clearInputs();
        bus.i_valid = 1'b1;
        bus.i_sel_a = 1'b1; bus.i_pc = 32'h1000; bus.i_rs1_addr = 5'd3;
        bus.i_sel_b = 1'b1; bus.i_imm = 32'hFFFFFFFC; bus.i_rs2_addr = 5'd3;
        bus.i_ex_we = 1'b1; bus.i_ex_is_load = 1'b1; bus.i_ex_rd = 5'd3;
        #1;
        checks++;
        if (bus.o_stall !== 1'b0) begin failures++; $display("[TB] FAIL selimm_nostall got=%b exp=0", bus.o_stall); end
        step();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data_1 !== 32'h1000 || bus.o_data_2 !== 32'hFFFFFFFC) begin
            failures++; $display("[TB] FAIL selimm_operands got=%b/%h/%h exp=1/1000/fffffffc",
                                 bus.o_valid, bus.o_data_1, bus.o_data_2);
        end
        clearInputs();
        step();
    endtask

    task automatic test_backpressure();
        clearInputs();
        bus.i_valid = 1'b1; bus.i_rs1_addr = 5'd1; bus.i_rs1_data = 32'h11; bus.i_alu_op = 4'h2;
        step();
        bus.i_ready = 1'b0; bus.i_rs1_data = 32'h22; bus.i_alu_op = 4'h5;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.o_ready !== 1'b0) begin failures++; $display("[TB] FAIL hold_ready[%0d] got=%b exp=0", i, bus.o_ready); end
            step();
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_data_1 !== 32'h11 || bus.o_alu_op !== 4'h2) begin
                failures++; $display("[TB] FAIL hold_frozen[%0d] got=%b/%h/%h exp=1/11/2",
                                     i, bus.o_valid, bus.o_data_1, bus.o_alu_op);
            end
        end
        bus.i_ready = 1'b1;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1) begin failures++; $display("[TB] FAIL hold_release got=%b exp=1", bus.o_ready); end
        step();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data_1 !== 32'h22 || bus.o_alu_op !== 4'h5) begin
            failures++; $display("[TB] FAIL back_to_back got=%b/%h/%h exp=1/22/5", bus.o_valid, bus.o_data_1, bus.o_alu_op);
        end
        bus.i_valid = 1'b0;
        step();
        checks++;
        if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL hold_drain got=%b exp=0", bus.o_valid); end
    endtask

    task automatic test_flush();
        clearInputs();
        bus.i_valid = 1'b1; bus.i_rs1_addr = 5'd1; bus.i_rs1_data = 32'h33; bus.i_flush = 1'b1;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_ready got=%b exp=1", bus.o_ready); end
        step();
        checks++;
        if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_beats_accept got=%b exp=0", bus.o_valid); end
        bus.i_flush = 1'b0;
        step();
        bus.i_ready = 1'b0; bus.i_valid = 1'b0; bus.i_flush = 1'b1;
        step();
        checks++;
        if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_held got=%b exp=0", bus.o_valid); end
        clearInputs();
        step();
    endtask

    task automatic test_reset_mid();
        clearInputs();
        bus.i_valid = 1'b1; bus.i_rs1_addr = 5'd1; bus.i_rs1_data = 32'h44;
        step();
        bus.i_ready = 1'b0; bus.i_valid = 1'b0;
        step();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data_1 !== 32'h44) begin
            failures++; $display("[TB] FAIL midreset_pre got=%b/%h exp=1/44", bus.o_valid, bus.o_data_1);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_data_1 !== 32'h0 || bus.o_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL midreset_async got=%b/%h/%b exp=0/0/1", bus.o_valid, bus.o_data_1, bus.o_ready);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        i_rst_n  = 1'b0;
        clearInputs();
        test_reset();
        test_basic();
        test_forward();
        test_load_use();
        test_sel_imm();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
